divsqrt_ret_pipe_hs: RTL and testbench
======================================

Name: divsqrt_ret_pipe_hs

Overview:
- Parametrised successor to the fixed divsqrt output retiming chain: an elastic, back-pressurable result pipeline for the FP divide/sqrt datapath.
- Carries WIDTH-bit results plus a TAG_W-bit sideband (opcode/fmt/ID) through DEPTH register stages, each with a valid bit.
- Adds valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count; the old free-running shift chain had none of these.
- Sits between the divsqrt core output and the FPU writeback/arbiter. DEPTH gives the synthesis tool registers to retime into the core.

Parameters:
- DEPTH, 2, number of register stages (0 = combinational pass-through, 1..16 legal).
- WIDTH, 32, result data width.
- TAG_W, 4, sideband width carried alongside data (e.g. {opcode[1:0], fmt, id}).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a result on in_data/in_tag.
- in_ready  out  1  pipeline accepts this cycle.
- in_data  in  WIDTH  result from the divsqrt core.
- in_tag  in  TAG_W  sideband.
- flush  in  1  synchronous kill of all in-flight entries.
- out_valid  out  1  out_data/out_tag hold a result.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  sideband.
- count  out  $clog2(DEPTH+1)  (min 1 bit)  number of valid stages.

Behaviour:
- Reset: while rst_n=0, all stage valids, data, tags and count clear to 0 immediately (asynchronous). Therefore out_valid=0, out_data=0, out_tag=0, count=0. in_ready=1 after reset, since all stages are empty.
- Stage k (0 = input side, DEPTH-1 = output side) holds v[k], d[k], t[k].
- Advance rules:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
- Stage k loads from stage k-1 (stage 0 loads from the inputs) when adv[k]=1.
  - Loaded valid = v[k-1] for k>0; for stage 0 it is in_valid & in_ready.
  - Data/tag load only when the incoming valid=1; otherwise they hold. Keep data enables minimal.
- in_ready = adv[0]. The ready path is combinational from out_ready; no skid buffer.
- Outputs come straight from the last stage: out_valid=v[DEPTH-1], out_data=d[DEPTH-1], out_tag=t[DEPTH-1].
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Once out_valid=1, out_data/out_tag stay stable until the output transfer.
- Latency: a result accepted in cycle N appears with out_valid=1 in cycle N+DEPTH if there has been no stall. Throughput is 1 per cycle with out_ready held high.
- Bubble collapsing: an empty stage always accepts. With out_ready=0 the pipe fills to DEPTH entries before in_ready drops.
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- count: registered; next = count + in_xfer − out_xfer. Simultaneous in and out transfers leave count unchanged. count==DEPTH implies in_ready = out_ready.
- flush (synchronous, highest priority):
  - Next cycle, all v[k]=0 and count=0.
  - Any input transfer in the flush cycle is discarded; in_ready is still driven per normal rules.
  - An output transfer in the same cycle still completes; the consumer sees it.
- Asynchronous reset mid-stream kills all in-flight entries at once.
- DEPTH=0: in_ready=out_ready, out_valid=in_valid, out_data=in_data, out_tag=in_tag, count=0. flush has no effect.

Test Plan:
- DEPTH=2, out_ready=1. Drive 8 back-to-back results with in_data=0x3F800000+i, in_tag=i. Required: out_valid rises 2 cycles after the first accept; 8 consecutive outputs in order; count steady at 2.
- DEPTH=3, out_ready=0. Drive continuous in_valid. Required: exactly 3 accepts, then in_ready=0 and count=3. Raise out_ready: the first output is the first input (0x40000000, tag 0) and in_ready=1 in that same cycle.
- DEPTH=4, random in_valid/out_ready at 50% over 2000 items. Required: scoreboard shows FIFO order, no loss or duplication, out_data stable while out_valid & !out_ready, count matches the model every cycle.
- DEPTH=2, 2 entries in flight. Assert flush with in_valid=1, in_data=0xDEADBEEF. Required: next cycle count=0 and out_valid=0; 0xDEADBEEF never appears.
- Pull rst_n low mid-stream with 3 entries in DEPTH=4 (no clock edge). Required: out_valid=0, out_data=0, count=0 asynchronously; after release, in_ready=1 and the first new input emerges after 4 cycles.
- DEPTH=0. Toggle in_valid/out_ready. Required: outputs mirror inputs in the same cycle, in_ready==out_ready, count=0.

Source files
------------

// File: rtl/divsqrt_ret_pipe_hs.sv
// Elastic result pipeline for the FP divide/sqrt datapath: DEPTH valid-tagged
// register stages with valid/ready handshake, bubble collapsing, flush and occupancy.
module divsqrt_ret_pipe_hs #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int CNT_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] count
);

  if (DEPTH == 0) begin : g_bypass
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign out_tag   = in_tag;
    assign count     = '0;

    logic unused_bypass;
    assign unused_bypass = &{1'b0, clk, rst_n, flush};
  end else begin : g_pipe
    logic [DEPTH-1:0] v_q, v_d, adv, src_v;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [TAG_W-1:0] t_q [DEPTH];
    logic [TAG_W-1:0] t_d [DEPTH];
    logic [TAG_W-1:0] src_t [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_xfer, out_xfer;

    // A stage may advance if it is empty or the stage ahead of it advances;
    // the chain runs from out_ready back to in_ready with no storage in between.
    always_comb begin : adv_chain
      logic a;
      a   = out_ready;
      adv = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        a      = !v_q[k] | a;
        adv[k] = a;
      end
    end

    assign in_ready = adv[0];
    assign in_xfer  = in_valid & adv[0];
    assign out_xfer = v_q[DEPTH-1] & out_ready;

    always_comb begin
      // NOTE: every always_comb output gets a default up front so no path leaves it unassigned (no latch).
      src_v    = '0;
      src_v[0] = in_xfer;
      src_d[0] = in_data;
      src_t[0] = in_tag;
      for (int k = 1; k < DEPTH; k++) begin
        src_v[k] = v_q[k-1];
        src_d[k] = d_q[k-1];
        src_t[k] = t_q[k-1];
      end

      v_d = v_q;
      d_d = d_q;
      t_d = t_q;
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k] = src_v[k];
          // Payload only moves with a real entry, so bubbles leave data flops idle.
          if (src_v[k]) begin
            d_d[k] = src_d[k];
            t_d[k] = src_t[k];
          end
        end
      end
      if (flush) v_d = '0;

      count_d = flush ? '0 : count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end

    // NOTE: data/tag stages are reset along with the valids because out_data/out_tag must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q     <= '0;
        count_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          d_q[k] <= '0;
          t_q[k] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
        v_q     <= v_d;
        d_q     <= d_d;
        t_q     <= t_d;
        count_q <= count_d;
      end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_tag   = t_q[DEPTH-1];
    assign count     = count_q;
  end

endmodule

// File: tb/tb_divsqrt_ret_pipe_hs.sv
// Self-checking bench: DEPTH 0/2/3/4 instances share one stimulus bus; each
// scenario checks the instance it targets against queue/arithmetic expectations.
module tb_divsqrt_ret_pipe_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_data;
  logic [3:0]  in_tag;

  logic ir0, ov0, ir2, ov2, ir3, ov3, ir4, ov4;
  logic [31:0] od0, od2, od3, od4;
  logic [3:0]  ot0, ot2, ot3, ot4;
  logic [0:0]  cnt0;
  logic [1:0]  cnt2, cnt3;
  logic [2:0]  cnt4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  divsqrt_ret_pipe_hs #(.DEPTH(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_tag(in_tag), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_tag(ot0), .count(cnt0));
  divsqrt_ret_pipe_hs #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .in_tag(in_tag), .flush(flush), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_tag(ot2), .count(cnt2));
  divsqrt_ret_pipe_hs #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .in_tag(in_tag), .flush(flush), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_tag(ot3), .count(cnt3));
  divsqrt_ret_pipe_hs #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .in_tag(in_tag), .flush(flush), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_tag(ot4), .count(cnt4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    in_tag    = '0;
  endtask

  // Reset with no clock dependence for the checks; release #1 after a rising edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_ov2", ov2, 0);  check("rst_od2", od2, 0);  check("rst_cnt2", cnt2, 0);
    check("rst_ir2", ir2, 1);  check("rst_ov4", ov4, 0);  check("rst_ot4", ot4, 0);
    check("rst_cnt4", cnt4, 0); check("rst_ir3", ir3, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam int N_RAND = 2000;
  logic [35:0] sb[$];
  logic [36:0] held;
  bit          hold;
  bit          exp_rdy;
  int          acc, emit, cyc;

  initial begin
    // Back-to-back stream through DEPTH=2 with the consumer always ready.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (c < 8);
      in_data   = 32'h3F80_0000 + 32'(c);
      in_tag    = 4'(c);
      @(negedge clk);
      check("s1_ir", ir2, 1);
      check("s1_ov", ov2, (c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        check("s1_data", od2, 32'h3F80_0000 + 32'(c - 2));
        check("s1_tag", ot2, 4'(c - 2));
      end
      check("s1_cnt", cnt2, ((c < 8) ? c : 8) - ((c - 2 < 0) ? 0 : ((c - 2 > 8) ? 8 : c - 2)));
    end

    // DEPTH=3 fill with consumer stalled, then release.
    do_reset();
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 32'h4000_0000 + 32'(acc);
      in_tag    = 4'(acc);
      out_ready = (c == 6);
      @(negedge clk);
      if (c < 6) begin
        check("s2_ir", ir3, (c < 3));
        check("s2_cnt", cnt3, (c < 3) ? c : 3);
        check("s2_ov", ov3, (c >= 3));
        if (c >= 3) check("s2_hold", {ot3, od3}, {4'h0, 32'h4000_0000});
        if (c < 3) acc++;
      end else begin
        check("s2_acc", acc, 3);
        check("s2_rel_ir", ir3, 1);
        check("s2_rel_ov", ov3, 1);
        check("s2_rel_data", od3, 32'h4000_0000);
        check("s2_rel_tag", ot3, 0);
      end
    end

    // Random traffic on DEPTH=4 against a queue scoreboard; DEPTH=0 mirrors inputs.
    do_reset();
    sb.delete();
    acc = 0; emit = 0; cyc = 0; hold = 0; held = '0;
    while ((acc < N_RAND || sb.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = (acc < N_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("r_cnt", cnt4, sb.size());
      exp_rdy = (sb.size() < 4) || out_ready;
      check("r_ir", ir4, exp_rdy);
      if (sb.size() == 0) check("r_empty_ov", ov4, 0);
      else if (ov4) check("r_head", {ot4, od4}, sb[0]);
      if (hold) check("r_stable", {ov4, ot4, od4}, {1'b1, held[35:0]});
      hold = ov4 && !out_ready;
      held = {1'b0, ot4, od4};
      check("d0_ir", ir0, out_ready);
      check("d0_ov", ov0, in_valid);
      check("d0_pay", {ot0, od0}, {in_tag, in_data});
      check("d0_cnt", cnt0, 0);
      if (ov4 && out_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        emit++;
      end
      if (in_valid && exp_rdy) begin
        sb.push_back({in_tag, in_data});
        acc++;
      end
      cyc++;
    end
    check("r_emitted", emit, N_RAND);

    // Flush on DEPTH=2 with two entries in flight and a colliding input.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid  = (c <= 2);
      in_data   = (c == 2) ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(c);
      in_tag    = (c == 2) ? 4'hF : 4'(c + 1);
      flush     = (c == 2);
      out_ready = (c >= 2);
      @(negedge clk);
      if (c < 2) check("f_ir", ir2, 1);
      if (c == 2) begin
        check("f_cnt_pre", cnt2, 2);
        check("f_ir_flush", ir2, 1);
        check("f_ov_flush", ov2, 1);
        check("f_data_flush", od2, 32'h1111_0000);
      end
      if (c > 2) begin
        check("f_ov_after", ov2, 0);
        check("f_cnt_after", cnt2, 0);
      end
    end

    // Asynchronous reset mid-stream on DEPTH=4.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid  = (c < 3);
      in_data   = 32'h5000_0000 + 32'(c);
      in_tag    = 4'(c);
      out_ready = 1'b0;
      @(negedge clk);
    end
    check("a_ov_pre", ov4, 1);
    check("a_od_pre", od4, 32'h5000_0000);
    check("a_cnt_pre", cnt4, 3);
    #1 rst_n = 1'b0;
    #1;
    check("a_ov_rst", ov4, 0);
    check("a_od_rst", od4, 0);
    check("a_ot_rst", ot4, 0);
    check("a_cnt_rst", cnt4, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("a_ir_rel", ir4, 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      in_valid  = (c == 0);
      in_data   = 32'h6000_0000;
      in_tag    = 4'h5;
      out_ready = 1'b1;
      @(negedge clk);
      check("a_ov_lat", ov4, (c == 4));
      if (c == 4) check("a_pay_lat", {ot4, od4}, {4'h5, 32'h6000_0000});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
